// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/redirect controller.
// Also carries the trap encodings decode matches against.
package hazard_pkg;

    localparam int NR_REG       = 32;
    localparam int REG_W        = 5;
    localparam int CNT_W        = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int FC_W         = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;
    localparam logic [31:0] MRET_INSN  = 32'h3020_0073;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        TRAP  = 2'd3
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute/writeback control bundle seen by the hazard unit.
// The master side is the pipeline, the slave side is hazard_ctrl.
interface hazard_if;
    import hazard_pkg::*;

    logic     id_valid;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    logic     id_rs1_used;
    logic     id_rs2_used;
    reg_idx_t id_rd;
    logic     id_rd_wen;
    logic     id_trap;
    logic     ex_ready;
    logic     wb_valid;
    reg_idx_t wb_rd;
    logic     wb_wen;
    logic     redirect;
    logic     issue_fire;
    logic     pipe_stop;
    logic     inst_clear;
    logic     trap_go;
    logic     sb_empty;
    logic     sb_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_wen, id_trap, ex_ready,
        output wb_valid, wb_rd, wb_wen, redirect,
        input  issue_fire, pipe_stop, inst_clear, trap_go,
        input  sb_empty, sb_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_wen, id_trap, ex_ready,
        input  wb_valid, wb_rd, wb_wen, redirect,
        output issue_fire, pipe_stop, inst_clear, trap_go,
        output sb_empty, sb_err
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters with read ports for decode.
// x0 is never tracked; a writeback to an idle register sets a sticky error.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     inc_i,
    input  reg_idx_t inc_rd_i,
    input  logic     dec_i,
    input  reg_idx_t dec_rd_i,
    input  reg_idx_t rs1_i,
    input  reg_idx_t rs2_i,
    input  reg_idx_t rd_i,
    output logic     rs1_pend_o,
    output logic     rs2_pend_o,
    output logic     rd_sat_o,
    output logic     sb_empty_o,
    output logic     sb_err_o
);

    logic [NR_REG-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NR_REG-1:0] nz, inc_vec, dec_vec, dec_hit;
    logic err_q, err_d;

    assign inc_vec = (inc_i && inc_rd_i != '0)
                   ? (NR_REG'(1) << inc_rd_i) : '0;
    assign dec_vec = (dec_i && dec_rd_i != '0)
                   ? (NR_REG'(1) << dec_rd_i) : '0;
    assign dec_hit = dec_vec & nz;

    always_comb begin
        nz = '0;
        for (int r = 0; r < NR_REG; r++) begin
            nz[r] = |pend_q[r];
        end
    end

    // Simultaneous inc and dec of one register cancel out.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NR_REG; r++) begin
            if (inc_vec[r] && !dec_hit[r]) begin
                pend_d[r] = pend_q[r] + CNT_W'(1);
            end else if (dec_hit[r] && !inc_vec[r]) begin
                pend_d[r] = pend_q[r] - CNT_W'(1);
            end
        end
    end

    assign err_d = err_q | (|(dec_vec & ~nz));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign rs1_pend_o = nz[rs1_i];
    assign rs2_pend_o = nz[rs2_i];
    assign rd_sat_o   = &pend_q[rd_i];
    assign sb_empty_o = ~|nz;
    assign sb_err_o   = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage stall/squash control and redirect/trap sequencing.
// Traps wait for an empty scoreboard before trap_go fires.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    hazard_if.slave hz
);

    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    hz_state_e state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic rs1_pend, rs2_pend, rd_sat, sb_empty;
    logic raw, sat, is_run, fire, clear, tgo;

    hazard_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (fire & hz.id_rd_wen),
        .inc_rd_i   (hz.id_rd),
        .dec_i      (hz.wb_valid & hz.wb_wen),
        .dec_rd_i   (hz.wb_rd),
        .rs1_i      (hz.id_rs1),
        .rs2_i      (hz.id_rs2),
        .rd_i       (hz.id_rd),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .rd_sat_o   (rd_sat),
        .sb_empty_o (sb_empty),
        .sb_err_o   (hz.sb_err)
    );

    assign raw = hz.id_valid
               & ((hz.id_rs1_used & rs1_pend)
                | (hz.id_rs2_used & rs2_pend));
    assign sat = hz.id_valid & hz.id_rd_wen & rd_sat;
    assign is_run = (state_q == RUN);

    assign fire = hz.id_valid & hz.ex_ready & is_run
                & ~raw & ~sat & ~hz.redirect & ~hz.id_trap;

    // Redirect squashes IF/ID in whatever state it arrives.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        clear   = 1'b0;
        tgo     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz.redirect) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                    clear   = 1'b1;
                end else if (hz.id_valid && hz.id_trap) begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                clear = 1'b1;
                if (hz.redirect) begin
                    fcnt_d = FLUSH_LOAD;
                end else if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            DRAIN: begin
                if (hz.redirect) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                    clear   = 1'b1;
                end else if (sb_empty) begin
                    state_d = TRAP;
                end
            end
            TRAP: begin
                tgo     = 1'b1;
                clear   = 1'b1;
                state_d = FLUSH;
                fcnt_d  = FLUSH_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign hz.issue_fire = fire;
    assign hz.pipe_stop  = (is_run & (raw | sat | ~hz.ex_ready
                                    | hz.id_trap))
                         | (state_q == DRAIN)
                         | (state_q == TRAP);
    assign hz.inst_clear = clear;
    assign hz.trap_go    = tgo;
    assign hz.sb_empty   = sb_empty;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal checks,
// then random traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    hazard_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: pending counts, sticky error, remaining clear cycles,
    // draining flag and trap-this-cycle flag.
    int  m_pend [NR_REG];
    bit  m_err, m_drain, m_trap, m_ok;
    int  m_rem;

    bit  fl, run, e_raw, e_sat, e_fire, e_stop, e_clear, e_empty, dok;

    always @(negedge clk) begin
        fl  = (m_rem > 0);
        run = !fl && !m_drain && !m_trap;
        e_raw = hz.id_valid
              && ((hz.id_rs1_used && hz.id_rs1 != 0
                   && m_pend[hz.id_rs1] != 0)
               || (hz.id_rs2_used && hz.id_rs2 != 0
                   && m_pend[hz.id_rs2] != 0));
        e_sat = hz.id_valid && hz.id_rd_wen && hz.id_rd != 0
              && m_pend[hz.id_rd] == (1 << CNT_W) - 1;
        e_fire = run && hz.id_valid && hz.ex_ready && !e_raw
               && !e_sat && !hz.redirect && !hz.id_trap;
        e_stop = (run && (e_raw || e_sat || !hz.ex_ready
                          || hz.id_trap)) || m_drain || m_trap;
        e_clear = fl || m_trap || hz.redirect;
        e_empty = 1'b1;
        for (int r = 0; r < NR_REG; r++) begin
            if (m_pend[r] != 0) e_empty = 1'b0;
        end
        if (m_ok) begin
            chk("m_issue_fire", 32'(hz.issue_fire), 32'(e_fire));
            chk("m_pipe_stop", 32'(hz.pipe_stop), 32'(e_stop));
            chk("m_inst_clear", 32'(hz.inst_clear), 32'(e_clear));
            chk("m_trap_go", 32'(hz.trap_go), 32'(m_trap));
            chk("m_sb_empty", 32'(hz.sb_empty), 32'(e_empty));
            chk("m_sb_err", 32'(hz.sb_err), 32'(m_err));
        end
        if (!rst_n) begin
            foreach (m_pend[r]) m_pend[r] = 0;
            m_err = 0; m_drain = 0; m_trap = 0; m_rem = 0;
            m_ok = 1;
        end else if (m_ok) begin
            if (hz.wb_valid && hz.wb_wen && hz.wb_rd != 0) begin
                dok = (m_pend[hz.wb_rd] != 0);
                if (!dok) m_err = 1;
            end else begin
                dok = 0;
            end
            if (e_fire && hz.id_rd_wen && hz.id_rd != 0)
                m_pend[hz.id_rd]++;
            if (dok) m_pend[hz.wb_rd]--;
            if (m_trap) begin
                m_trap = 0;
                m_rem = FLUSH_CYCLES;
            end else if (hz.redirect) begin
                m_drain = 0;
                m_rem = FLUSH_CYCLES;
            end else if (fl) begin
                m_rem--;
            end else if (m_drain) begin
                if (e_empty) begin
                    m_drain = 0;
                    m_trap = 1;
                end
            end else if (hz.id_valid && hz.id_trap) begin
                m_drain = 1;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic inst(input bit v, input int rs1, input bit u1,
                        input int rs2, input bit u2, input int rd,
                        input bit w, input bit tr);
        hz.id_valid    = v;
        hz.id_rs1      = reg_idx_t'(rs1);
        hz.id_rs1_used = u1;
        hz.id_rs2      = reg_idx_t'(rs2);
        hz.id_rs2_used = u2;
        hz.id_rd       = reg_idx_t'(rd);
        hz.id_rd_wen   = w;
        hz.id_trap     = tr;
    endtask

    task automatic wb(input bit v, input int rd);
        hz.wb_valid = v;
        hz.wb_wen   = v;
        hz.wb_rd    = reg_idx_t'(rd);
    endtask

    task automatic wr(input int rd);
        inst(1, 0, 0, 0, 0, rd, 1, 0);
    endtask

    task automatic idle();
        inst(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick_wb();
        int s;
        int r;
        s = $urandom_range(0, 6);
        for (int k = 0; k < 7; k++) begin
            r = 1 + (s + k) % 7;
            if (m_pend[r] != 0) return r;
        end
        return $urandom_range(1, 7);
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        wb(0, 0);
        hz.redirect = 0;
        hz.ex_ready = 1;
        nxt(); nxt();
        rst_n = 1'b1;
        mid();
        chk("rst_pipe_stop", 32'(hz.pipe_stop), 0);
        chk("rst_issue_fire", 32'(hz.issue_fire), 0);
        chk("rst_sb_empty", 32'(hz.sb_empty), 1);
        chk("rst_inst_clear", 32'(hz.inst_clear), 0);
        chk("rst_trap_go", 32'(hz.trap_go), 0);
        chk("rst_sb_err", 32'(hz.sb_err), 0);
        nxt();

        // RAW on x5
        wr(5);
        mid(); chk("raw_c0_fire", 32'(hz.issue_fire), 1);
        nxt();
        inst(1, 5, 1, 0, 0, 6, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) wb(1, 5);
            mid();
            chk("raw_stop", 32'(hz.pipe_stop), 1);
            chk("raw_nofire", 32'(hz.issue_fire), 0);
            nxt();
        end
        wb(0, 0);
        mid(); chk("raw_c5_fire", 32'(hz.issue_fire), 1);
        nxt();
        idle(); wb(1, 6); nxt(); wb(0, 0);

        // x0 never tracked
        wr(0); nxt();
        inst(1, 0, 1, 0, 1, 0, 0, 0);
        mid();
        chk("x0_read_fire", 32'(hz.issue_fire), 1);
        chk("x0_empty", 32'(hz.sb_empty), 1);
        nxt();

        // x7 same-cycle inc/dec
        wr(7); nxt();
        wr(7); wb(1, 7);
        mid(); chk("x7_fire", 32'(hz.issue_fire), 1);
        nxt();
        idle(); wb(0, 0);
        mid(); chk("x7_pending", 32'(hz.sb_empty), 0);
        nxt();
        wb(1, 7); nxt(); wb(0, 0);
        mid(); chk("x7_drained", 32'(hz.sb_empty), 1);
        nxt();

        // saturation on x3
        repeat (3) begin wr(3); nxt(); end
        mid();
        chk("sat_stop", 32'(hz.pipe_stop), 1);
        chk("sat_nofire", 32'(hz.issue_fire), 0);
        nxt();
        wb(1, 3);
        mid(); chk("sat_stop_wb", 32'(hz.pipe_stop), 1);
        nxt();
        wb(0, 0);
        mid(); chk("sat_release", 32'(hz.issue_fire), 1);
        nxt();
        idle();
        repeat (3) begin wb(1, 3); nxt(); end
        wb(0, 0);

        // underflow on x9
        wb(1, 9); nxt(); wb(0, 0);
        mid(); chk("uflow_err", 32'(hz.sb_err), 1);
        nxt(); nxt();
        mid(); chk("uflow_sticky", 32'(hz.sb_err), 1);
        chk("uflow_empty", 32'(hz.sb_empty), 1);
        nxt();

        // single redirect
        wr(8); hz.redirect = 1;
        mid();
        chk("redir_nofire", 32'(hz.issue_fire), 0);
        chk("redir_clear0", 32'(hz.inst_clear), 1);
        nxt();
        hz.redirect = 0;
        mid(); chk("redir_clear1", 32'(hz.inst_clear), 1); nxt();
        mid(); chk("redir_clear2", 32'(hz.inst_clear), 1); nxt();
        mid();
        chk("redir_done", 32'(hz.inst_clear), 0);
        chk("redir_resume", 32'(hz.issue_fire), 1);
        nxt();
        idle(); wb(1, 8); nxt(); wb(0, 0);

        // redirect during flush
        hz.redirect = 1; nxt();
        mid(); chk("redir2_clear", 32'(hz.inst_clear), 1); nxt();
        hz.redirect = 0;
        mid(); chk("redir2_ext1", 32'(hz.inst_clear), 1); nxt();
        mid(); chk("redir2_ext2", 32'(hz.inst_clear), 1); nxt();
        mid(); chk("redir2_done", 32'(hz.inst_clear), 0); nxt();

        // trap drain with x10/x11 pending
        wr(10); nxt(); wr(11); nxt();
        inst(1, 0, 0, 0, 0, 0, 0, 1);
        mid();
        chk("trap_stop", 32'(hz.pipe_stop), 1);
        chk("trap_nofire", 32'(hz.issue_fire), 0);
        nxt();
        mid(); chk("drain_stop", 32'(hz.pipe_stop), 1); nxt();
        wb(1, 10); nxt();
        wb(1, 11);
        mid(); chk("drain_nogo0", 32'(hz.trap_go), 0); nxt();
        wb(0, 0);
        mid(); chk("drain_nogo1", 32'(hz.trap_go), 0); nxt();
        mid();
        chk("trap_go", 32'(hz.trap_go), 1);
        chk("trap_clear", 32'(hz.inst_clear), 1);
        nxt();
        idle();
        mid();
        chk("trap_go_once", 32'(hz.trap_go), 0);
        chk("trap_fl1", 32'(hz.inst_clear), 1);
        nxt();
        mid(); chk("trap_fl2", 32'(hz.inst_clear), 1); nxt();
        mid(); chk("trap_fl_done", 32'(hz.inst_clear), 0); nxt();

        // redirect while draining cancels the trap
        wr(10); nxt();
        inst(1, 0, 0, 0, 0, 0, 0, 1); nxt();
        hz.redirect = 1;
        mid(); chk("dr_redir_nogo", 32'(hz.trap_go), 0); nxt();
        hz.redirect = 0; idle(); wb(1, 10);
        mid();
        chk("dr_flush", 32'(hz.inst_clear), 1);
        chk("dr_flush_nogo", 32'(hz.trap_go), 0);
        nxt();
        wb(0, 0);
        mid(); chk("dr_nogo2", 32'(hz.trap_go), 0); nxt();
        mid(); chk("dr_nogo3", 32'(hz.trap_go), 0);
        chk("dr_run", 32'(hz.inst_clear), 0);
        nxt();

        // reset in the middle of a flush
        wr(12); nxt();
        idle(); hz.redirect = 1; nxt();
        hz.redirect = 0; rst_n = 1'b0; nxt();
        rst_n = 1'b1;
        mid();
        chk("mrst_clear", 32'(hz.inst_clear), 0);
        chk("mrst_empty", 32'(hz.sb_empty), 1);
        chk("mrst_err", 32'(hz.sb_err), 0);
        chk("mrst_stop", 32'(hz.pipe_stop), 0);
        nxt();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            hz.id_valid    = ($urandom_range(0, 3) != 0);
            hz.id_rs1      = reg_idx_t'($urandom_range(0, 7));
            hz.id_rs2      = reg_idx_t'($urandom_range(0, 7));
            hz.id_rs1_used = $urandom_range(0, 1);
            hz.id_rs2_used = $urandom_range(0, 1);
            hz.id_rd       = reg_idx_t'($urandom_range(0, 7));
            hz.id_rd_wen   = ($urandom_range(0, 3) != 0);
            hz.id_trap     = ($urandom_range(0, 19) == 0);
            hz.ex_ready    = ($urandom_range(0, 7) != 0);
            hz.redirect    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) == 0) begin
                wb(1, ($urandom_range(0, 49) == 0)
                      ? $urandom_range(0, 7) : pick_wb());
                hz.wb_wen = ($urandom_range(0, 9) != 0);
            end else begin
                wb(0, 0);
            end
            nxt();
        end
        rst_n = 1'b1;
        idle(); wb(0, 0); hz.redirect = 0;
        nxt(); nxt();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
